multicycle_controller: RTL

Control unit for the multicycle MIPS-subset datapath. It is the driving end of the ALU's `ALUControl` interface. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. Every cycle it produces the datapath enables, the mux selects and the 3-bit ALU operation code consumed by the ALU.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/alu_decoder.sv | 29 ++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path:
// opcodes, funct codes, ALU operation codes and controller states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_NONE marks states that do not use the ALU; it yields code 000.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp request (and Funct for R-type) to the 3-bit ALU code.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t     ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_AND;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FUNCT_ADD: ALUControl = ALU_ADD;
                    FUNCT_SUB: ALUControl = ALU_SUB;
                    FUNCT_AND: ALUControl = ALU_AND;
                    FUNCT_OR:  ALUControl = ALU_OR;
                    FUNCT_SLT: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle MIPS-subset datapath, with a
// sticky illegal-instruction flag and a retired-instruction counter.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state, state_nxt;
    aluop_t aluop;
    logic   mem_write_s, ir_write_s, reg_write_s, pc_en_s;
    logic   decode_illegal, retire;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    // NOTE: every output is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_nxt      = state;
        aluop          = ALUOP_NONE;
        IorD           = 1'b0;
        mem_write_s    = 1'b0;
        ir_write_s     = 1'b0;
        RegDst         = 1'b0;
        MemtoReg       = 1'b0;
        reg_write_s    = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        PCSrc          = 2'b00;
        pc_en_s        = 1'b0;
        decode_illegal = 1'b0;
        retire         = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                aluop      = ALUOP_ADD;
                ir_write_s = 1'b1;
                pc_en_s    = 1'b1;
                state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                aluop   = ALUOP_ADD;
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(Funct)) begin
                            state_nxt = S_RTYPEEX;
                        end else begin
                            state_nxt      = S_FETCH;
                            decode_illegal = 1'b1;
                        end
                    end
                    OP_BEQ:  state_nxt = S_BEQEX;
                    OP_ADDI: state_nxt = S_ADDIEX;
                    OP_J:    state_nxt = S_JEX;
                    default: begin
                        state_nxt      = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                aluop     = ALUOP_ADD;
                state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD      = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_s = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_s = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_RTYPEEX: begin
                ALUSrcA   = 1'b1;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst      = 1'b1;
                reg_write_s = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BEQEX: begin
                ALUSrcA   = 1'b1;
                aluop     = ALUOP_SUB;
                PCSrc     = 2'b01;
                pc_en_s   = Zero;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                aluop     = ALUOP_ADD;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_JEX: begin
                PCSrc     = 2'b10;
                pc_en_s   = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Write enables are gated by reset_n so they drop the instant reset asserts.
    assign MemWrite = mem_write_s & reset_n;
    assign IRWrite  = ir_write_s  & reset_n;
    assign RegWrite = reg_write_s & reset_n;
    assign PCEn     = pc_en_s     & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (decode_illegal) illegal <= 1'b1;
            if (retire)         retired <= retired + CNT_W'(1);
        end
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (aluop),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

endmodule
